alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator side of the ALU operand/opcode interface. Accepts R-type commands (funct, A, B)
//  on a valid/ready port and decodes funct to the 4-bit ALU opcode. Drives A/B/Opin to the
//  ALU, holds them stable for a fixed settle time, then captures result/zero and returns
//  them on a valid/ready response port. Sits between issue logic and the datapath ALU.
// PARAMETERS
//  WIDTH        32  operand/result width; must match ALU
//  WAIT_CYCLES  2   cycles ALU inputs are held before capture (>=2, covers registered SLT)
//  CNT_W        16  width of statistics counters (only with ALU_SEQ_STATS_EN)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command
//  cmd_funct  in   6      R-type funct field
//  cmd_a      in   WIDTH  operand A
//  cmd_b      in   WIDTH  operand B
//  alu_a      out  WIDTH  to ALU A
//  alu_b      out  WIDTH  to ALU B
//  alu_op     out  4      to ALU Opin
//  alu_result in   WIDTH  from ALU result
//  alu_zero   in   1      from ALU zero
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      consumer accepts response
//  rsp_result out  WIDTH  captured result (0 on error)
//  rsp_zero   out  1      captured zero flag (0 on error)
//  rsp_err    out  1      1 = illegal funct, ALU not used
//  op_count   out  CNT_W  legal ops completed (ALU_SEQ_STATS_EN only)
//  err_count  out  CNT_W  illegal commands seen (ALU_SEQ_STATS_EN only)
// BEHAVIOUR
//  - One clock domain; rst asynchronous, active-high; all state resets immediately.
//  - Reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_*=0, alu_a/alu_b=0, alu_op=4'b0000.
//  - Decode: 20->0000 add, 22->0010 sub, 24->0100 and, 25->0101 or, 26->0110 xor,
//    27->0111 nor, 2A->1010 slt; any other funct is illegal.
//  - FSM IDLE: cmd_ready=1 (registered, only in IDLE). Accept on cmd_valid&cmd_ready at edge T.
//    Legal -> load alu_a/alu_b/alu_op at T, go WAIT, counter=WAIT_CYCLES-1.
//    Illegal -> alu_* unchanged, rsp_err=1, rsp_result=0, rsp_zero=0, go RESP.
//  - WAIT: alu_* held constant; counter decrements each cycle; at counter==0 capture
//    alu_result/alu_zero into rsp_result/rsp_zero, rsp_err=0, go RESP.
//    Capture edge = T+WAIT_CYCLES; rsp_valid first high in cycle after that edge.
//  - RESP: rsp_valid=1, rsp_* stable until rsp_valid&rsp_ready; then IDLE, cmd_ready=1 next cycle.
//    No back-to-back: a new command cannot be accepted in the RESP handshake cycle.
//  - alu_* keep last issued values while idle (no glitch to ALU between ops).
//  - cmd_valid while cmd_ready=0 is ignored; cmd_* not sampled outside IDLE.
//  - rst in WAIT/RESP aborts the op; pending response discarded, no rsp_valid emitted.
//  - Result/zero taken verbatim from ALU; no width extension or recomputation here.
// CONFIGURATION
//  ALU_SEQ_STATS_EN defined: op_count +1 on each legal capture, err_count +1 on each
//   illegal accept; both wrap modulo 2^CNT_W; reset to 0.
//  Undefined: op_count/err_count ports present, tied to 0; no counter flops.
// TESTING
//  - add 5+7 (funct 20): alu_op=0000; rsp_valid at T+3; result=12, zero=0, err=0.
//  - sub 9-9 (funct 22): result=0, zero=1; alu_a/alu_b stay 9 until next accept.
//  - slt A=3,B=5 then A=5,B=3 (funct 2A): results 1 then 0; alu_op=1010 held 2 cycles.
//  - funct 3F, A=1,B=2: rsp_valid at T+1, err=1, result=0; alu_op unchanged.
//  - rsp_ready low 5 cycles: rsp_* stable, cmd_ready=0, cmd_valid ignored; accept then IDLE.
//  - rst mid-WAIT: rsp_valid stays 0, cmd_ready=1 after release; stats (if EN) unchanged.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator side of the ALU operand/opcode interface. Accepts R-type commands
//   (funct, A, B) on a valid/ready port, decodes funct into the 4-bit ALU opcode,
//   drives A/B/opcode to the ALU and holds them for WAIT_CYCLES, then captures
//   result/zero and returns them on a valid/ready response port. Illegal funct
//   codes are answered immediately with rsp_err=1 and the ALU left untouched.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_funct/cmd_a/cmd_b    command payload
//   alu_a/alu_b/alu_op       operands and opcode to the ALU (held between ops)
//   alu_result/alu_zero      ALU outputs, sampled at the capture edge
//   rsp_valid/rsp_ready      response handshake
//   rsp_result/rsp_zero      captured ALU outputs (0 on error)
//   rsp_err                  illegal funct flag
//   op_count/err_count       statistics counters
//
// Configuration
//   ALU_SEQ_STATS_EN  defined: op_count/err_count count legal captures and
//                     illegal accepts (wrap modulo 2^CNT_W).
//                     undefined: both ports tied to 0, no counter flops.

module alu_cmd_sequencer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [5:0]       cmd_funct,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic       dec_legal;
    logic [3:0] dec_op;
    logic       accept;

    // funct -> ALU opcode
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = 4'b0000;
        case (cmd_funct)
            6'h20:   dec_op = 4'b0000;
            6'h22:   dec_op = 4'b0010;
            6'h24:   dec_op = 4'b0100;
            6'h25:   dec_op = 4'b0101;
            6'h26:   dec_op = 4'b0110;
            6'h27:   dec_op = 4'b0111;
            6'h2A:   dec_op = 4'b1010;
            default: dec_legal = 1'b0;
        endcase
    end

    // cmd_ready is a flop, so it is only ever high while sitting in StIdle
    assign accept = cmd_valid & cmd_ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (dec_legal) begin
                        alu_a_d  = cmd_a;
                        alu_b_d  = cmd_b;
                        alu_op_d = dec_op;
                        cnt_d    = CW'(WAIT_CYCLES - 1);
                        state_d  = StWait;
                    end else begin
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b0;
                        state_d      = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_err_d    = 1'b0;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 4'b0000;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

`ifdef ALU_SEQ_STATS_EN
    logic [CNT_W-1:0] op_count_q, err_count_q;
    logic             legal_done, err_accept;

    assign legal_done = (state_q == StWait) && (cnt_q == '0);
    assign err_accept = (state_q == StIdle) && accept && !dec_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            if (legal_done) op_count_q <= op_count_q + CNT_W'(1);
            if (err_accept) err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    assign op_count  = op_count_q;
    assign err_count = err_count_q;
`else
    assign op_count  = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a directed vector table, random
// commands scored against a funct-level reference model, and hand sequences for
// response back-pressure and reset during an operation.

module tb_alu_cmd_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned WAITC = 2;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready;
    logic [5:0]       cmd_funct;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero, rsp_err;
    logic [CNT_W-1:0] op_count, err_count;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .WAIT_CYCLES(WAITC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .op_count(op_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Registered ALU: output reflects inputs one edge late, so early capture is wrong
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, b);
        case (op)
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            4'b0111: return ~(a | b);
            4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        alu_result <= alu_fn(alu_op, alu_a, alu_b);
        alu_zero   <= (alu_fn(alu_op, alu_a, alu_b) == 32'd0);
    end

    // Reference model at the command level
    function automatic void ref_cmd(input logic [5:0] f, input logic [31:0] a, b,
                                    output logic legal, output logic [3:0] op,
                                    output logic [31:0] res);
        legal = 1'b1;
        op    = 4'b0000;
        res   = 32'd0;
        case (f)
            6'h20: begin op = 4'd0;  res = a + b; end
            6'h22: begin op = 4'd2;  res = a - b; end
            6'h24: begin op = 4'd4;  res = a & b; end
            6'h25: begin op = 4'd5;  res = a | b; end
            6'h26: begin op = 4'd6;  res = a ^ b; end
            6'h27: begin op = 4'd7;  res = ~(a | b); end
            6'h2A: begin op = 4'd10; res = {31'd0, $signed(a) < $signed(b)}; end
            default: legal = 1'b0;
        endcase
    endfunction

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] m_a = '0, m_b = '0;
    logic [3:0]  m_op = '0;
    int unsigned m_ops = 0, m_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One command through to the response handshake; x_err selects the error path
    task automatic run_cmd(input logic [5:0] f, input logic [31:0] a, b, input int rdelay,
                           input logic [3:0] x_op, input logic [31:0] x_res,
                           input logic x_zero, input logic x_err);
        int w;
        int k;
        logic [31:0] h_res;
        logic        h_zero, h_err;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_funct = f; cmd_a = a; cmd_b = b;
        w = 0;
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_funct = 6'($urandom); cmd_a = $urandom; cmd_b = $urandom;
        if (!x_err) begin m_a = a; m_b = b; m_op = x_op; m_ops++; end
        else m_errs++;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 20) begin
            check("wait_alu_a", alu_a, m_a);
            check("wait_alu_op", 32'(alu_op), 32'(m_op));
            check("wait_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        check("latency", k, x_err ? 32'd0 : 32'(WAITC));
        if (!rsp_valid) return;
        check("rsp_result", rsp_result, x_res);
        check("rsp_zero", 32'(rsp_zero), 32'(x_zero));
        check("rsp_err", 32'(rsp_err), 32'(x_err));
        check("alu_op", 32'(alu_op), 32'(m_op));
        check("alu_b", alu_b, m_b);
        h_res = rsp_result; h_zero = rsp_zero; h_err = rsp_err;
        for (int i = 0; i < rdelay; i++) begin
            cmd_valid = 1'b1; cmd_funct = 6'h20; cmd_a = $urandom; cmd_b = $urandom;
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_result", rsp_result, h_res);
            check("stall_flags", {30'd0, rsp_zero, rsp_err}, {30'd0, h_zero, h_err});
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        check("hs_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_alu_a", alu_a, m_a);
    endtask

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a, b;
        int          rdelay;
        logic [3:0]  op;
        logic [31:0] res;
        logic        zero, err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra, rb, rres;
        logic        rlegal;
        logic [3:0]  rop;
        logic [5:0]  legal_f[7];

        tbl[0]  = '{6'h20, 32'd5, 32'd7, 0, 4'b0000, 32'd12, 1'b0, 1'b0};
        tbl[1]  = '{6'h22, 32'd9, 32'd9, 5, 4'b0010, 32'd0, 1'b1, 1'b0};
        tbl[2]  = '{6'h2A, 32'd3, 32'd5, 0, 4'b1010, 32'd1, 1'b0, 1'b0};
        tbl[3]  = '{6'h2A, 32'd5, 32'd3, 1, 4'b1010, 32'd0, 1'b1, 1'b0};
        tbl[4]  = '{6'h3F, 32'd1, 32'd2, 0, 4'b0000, 32'd0, 1'b0, 1'b1};
        tbl[5]  = '{6'h24, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 4'b0100, 32'h00F0_000F, 1'b0, 1'b0};
        tbl[6]  = '{6'h25, 32'hF000_0000, 32'h0000_000F, 2, 4'b0101, 32'hF000_000F, 1'b0, 1'b0};
        tbl[7]  = '{6'h26, 32'hFFFF_0000, 32'hFF00_FF00, 0, 4'b0110, 32'h00FF_FF00, 1'b0, 1'b0};
        tbl[8]  = '{6'h27, 32'd0, 32'd0, 0, 4'b0111, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[9]  = '{6'h2A, 32'hFFFF_FFFF, 32'd1, 0, 4'b1010, 32'd1, 1'b0, 1'b0};
        tbl[10] = '{6'h22, 32'd0, 32'd1, 0, 4'b0010, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[11] = '{6'h21, 32'd4, 32'd4, 3, 4'b0000, 32'd0, 1'b0, 1'b1};
        tbl[12] = '{6'h20, 32'hFFFF_FFFF, 32'd1, 0, 4'b0000, 32'd0, 1'b1, 1'b0};
        legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_funct = '0; cmd_a = '0; cmd_b = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp", {rsp_result[30:0], rsp_zero}, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_alu", alu_a | alu_b | 32'(alu_op), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            run_cmd(tbl[i].funct, tbl[i].a, tbl[i].b, tbl[i].rdelay,
                    tbl[i].op, tbl[i].res, tbl[i].zero, tbl[i].err);

        for (int i = 0; i < 150; i++) begin
            rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 6)];
            ra = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            ref_cmd(rf, ra, rb, rlegal, rop, rres);
            run_cmd(rf, ra, rb, $urandom_range(0, 3), rop, rres,
                    rlegal && (rres == 32'd0), !rlegal);
        end

        // Reset in the middle of the settle wait
        @(negedge clk);
        cmd_valid = 1'b1; cmd_funct = 6'h20; cmd_a = 32'd100; cmd_b = 32'd23;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("midwait_busy", 32'(cmd_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ready", 32'(cmd_ready), 32'd1);
        check("rst_async_alu_a", alu_a, 32'd0);
        check("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
        m_a = '0; m_b = '0; m_op = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef ALU_SEQ_STATS_EN
        check("op_count_reset", 32'(op_count), 32'd0);
        check("err_count_reset", 32'(err_count), 32'd0);
        m_ops = 0; m_errs = 0;
`endif
        run_cmd(6'h22, 32'd50, 32'd8, 0, 4'b0010, 32'd42, 1'b0, 1'b0);
        run_cmd(6'h00, 32'd1, 32'd1, 0, 4'b0000, 32'd0, 1'b0, 1'b1);

`ifdef ALU_SEQ_STATS_EN
        check("op_count", 32'(op_count), m_ops % (1 << CNT_W));
        check("err_count", 32'(err_count), m_errs % (1 << CNT_W));
`else
        check("op_count_tied", 32'(op_count), 32'd0);
        check("err_count_tied", 32'(err_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
